// File: rtl/pwl_activation_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwl_activation_if
//  Brief    : Input/output valid-ready beat bus of the PWL activation unit.
//  Revision : 1.0  initial release
// ============================================================================
interface pwl_activation_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
);
    logic                      i_valid;
    logic                      i_ready;
    logic [1:0]                i_mode;
    logic [LANES*DATA_W-1:0]   i_data;
    logic                      o_valid;
    logic                      o_ready;
    logic [LANES*DATA_W-1:0]   o_data;

    modport master (
        output i_valid, i_mode, i_data, o_ready,
        input  i_ready, o_valid, o_data
    );

    modport slave (
        input  i_valid, i_mode, i_data, o_ready,
        output i_ready, o_valid, o_data
    );
endinterface
`default_nettype wire

// File: rtl/pwl_activation_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pwl_activation_unit
//  Brief    : 3-stage multi-lane bypass/ReLU/hard-sigmoid/hard-swish stage.
//             Optional clamp counter enabled by macro PWL_SAT_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pwl_activation_unit #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int LANES  = 4,
    parameter int SHIFT  = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pwl_activation_if.slave    bus,
    input  wire logic          i_cnt_clr,
    output logic [31:0]        o_sat_cnt
);
    localparam int W    = LANES * DATA_W;
    localparam int HALF = 1 << (FRAC_W - 1);
    localparam int SMAX = (1 << (DATA_W - 1)) - 1;
    localparam int HMAX = ((1 << FRAC_W) < SMAX) ? (1 << FRAC_W) : SMAX;

    localparam logic signed [DATA_W+1:0] HALF_E = (DATA_W+2)'(HALF);
    localparam logic signed [DATA_W+1:0] HMAX_E = (DATA_W+2)'(HMAX);
    localparam logic        [DATA_W-1:0] HMAX_D = DATA_W'(HMAX);
    localparam logic signed [2*DATA_W:0] PMAX   = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W:0] PMIN   = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    logic          w_adv;
    logic          v1_q, v2_q, v3_q;
    logic [1:0]    mode1_q, mode2_q;
    logic [W-1:0]  x1_q, x2_q, hs2_q, data3_q;
    logic [W-1:0]  w_hs_d, w_res_d;
    logic [LANES-1:0] w_sat_d;

    // Whole pipeline moves in lockstep; only a full output slot can stall it.
    assign w_adv       = !v3_q || bus.o_ready;
    assign bus.i_ready = w_adv;
    assign bus.o_valid = v3_q;
    assign bus.o_data  = data3_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_W-1:0] w_x1, w_x2;
        logic signed [DATA_W+1:0] w_sum;
        logic        [DATA_W-1:0] w_hs_l, w_hs2, w_swish, w_res_l;
        logic signed [2*DATA_W:0] w_prod, w_shr;

        assign w_x1   = x1_q[k*DATA_W +: DATA_W];
        assign w_sum  = ($signed({{2{w_x1[DATA_W-1]}}, w_x1}) >>> SHIFT) + HALF_E;
        assign w_hs_l = (w_sum < 0) ? '0 : ((w_sum > HMAX_E) ? HMAX_D : w_sum[DATA_W-1:0]);
        assign w_sat_d[k] = (w_sum < 0) || (w_sum > HMAX_E);
        assign w_hs_d[k*DATA_W +: DATA_W] = w_hs_l;

        assign w_x2  = x2_q[k*DATA_W +: DATA_W];
        assign w_hs2 = hs2_q[k*DATA_W +: DATA_W];
        // hs is never negative, so it is zero-extended into the signed product.
        assign w_prod  = $signed({{(DATA_W+1){w_x2[DATA_W-1]}}, w_x2})
                       * $signed({{(DATA_W+1){1'b0}}, w_hs2});
        assign w_shr   = w_prod >>> FRAC_W;
        assign w_swish = (w_shr > PMAX) ? PMAX[DATA_W-1:0]
                       : ((w_shr < PMIN) ? PMIN[DATA_W-1:0] : w_shr[DATA_W-1:0]);

        always_comb begin
            w_res_l = w_x2;
            case (mode2_q)
                2'd1:    w_res_l = w_x2[DATA_W-1] ? '0 : w_x2;
                2'd2:    w_res_l = w_hs2;
                2'd3:    w_res_l = w_swish;
                default: w_res_l = w_x2;
            endcase
        end

        assign w_res_d[k*DATA_W +: DATA_W] = v2_q ? w_res_l : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            mode1_q <= 2'd0;
            mode2_q <= 2'd0;
            x1_q    <= '0;
            x2_q    <= '0;
            hs2_q   <= '0;
            data3_q <= '0;
        end else if (w_adv) begin
            v1_q    <= bus.i_valid;
            mode1_q <= bus.i_valid ? bus.i_mode : 2'd0;
            x1_q    <= bus.i_valid ? bus.i_data : '0;
            v2_q    <= v1_q;
            mode2_q <= v1_q ? mode1_q : 2'd0;
            x2_q    <= v1_q ? x1_q : '0;
            hs2_q   <= v1_q ? w_hs_d : '0;
            v3_q    <= v2_q;
            data3_q <= w_res_d;
        end
    end

`ifdef PWL_SAT_CNT_EN
    logic [LANES-1:0] sat2_q, sat3_q;
    logic [31:0]      sat_cnt_q, sat_cnt_d, w_pop;
    logic [32:0]      w_cnt_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat2_q <= '0;
            sat3_q <= '0;
        end else if (w_adv) begin
            sat2_q <= v1_q ? w_sat_d : '0;
            // Clamp events only count for hard-sigmoid beats.
            sat3_q <= (v2_q && (mode2_q == 2'd2)) ? sat2_q : '0;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            w_pop = w_pop + 32'(sat3_q[k]);
        end
    end

    assign w_cnt_sum = {1'b0, sat_cnt_q} + {1'b0, w_pop};

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (i_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (v3_q && bus.o_ready) begin
            sat_cnt_d = w_cnt_sum[32] ? '1 : w_cnt_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign o_sat_cnt = sat_cnt_q;
`else
    logic w_unused_sink;
    assign w_unused_sink = ^{i_cnt_clr, w_sat_d};
    assign o_sat_cnt     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwl_activation_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwl_activation_unit
//  Brief    : Directed-vector and scoreboard bench for pwl_activation_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwl_activation_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [31:0] sat_cnt;
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 32'd0;

    pwl_activation_if #(.DATA_W(8), .LANES(4)) bus ();

    pwl_activation_unit #(.DATA_W(8), .FRAC_W(4), .LANES(4), .SHIFT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .i_cnt_clr (cnt_clr),
        .o_sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] din;
        logic [31:0] dexp;
        int          nsat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        logic [31:0] r;
        r = {d[7:0], c[7:0], b[7:0], a[7:0]};
        return r;
    endfunction

    // Independent integer reference for one beat.
    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d);
        logic [31:0] r;
        int x, hs, y;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            x  = int'($signed(d[l*8 +: 8]));
            hs = (x >>> 3) + 8;
            if (hs < 0)  hs = 0;
            if (hs > 16) hs = 16;
            case (m)
                2'd0: y = x;
                2'd1: y = (x < 0) ? 0 : x;
                2'd2: y = hs;
                default: begin
                    y = (x * hs) >>> 4;
                    if (y > 127)  y = 127;
                    if (y < -128) y = -128;
                end
            endcase
            r[l*8 +: 8] = y[7:0];
        end
        return r;
    endfunction

    task automatic send_one(input logic [1:0] m, input logic [31:0] d, input logic clr_at_out);
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_mode = m; bus.i_data = d; bus.o_ready = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_mode = 2'd0; bus.i_data = '0;
        chk("lat_n1_valid", bus.o_valid, 1'b0);
        @(negedge clk);
        chk("lat_n2_valid", bus.o_valid, 1'b0);
        chk("bubble_data", bus.o_data, 32'd0);
        @(negedge clk);
        chk("lat_n3_valid", bus.o_valid, 1'b1);
        cnt_clr = clr_at_out;
    endtask

    vec_t        vecs[7];
    logic [31:0] sq[100];
    logic [31:0] q[$];
    logic [31:0] cur_d, ev;
    logic [1:0]  cur_m;
    int          sent, got, cyc;

    initial begin
        bus.i_valid = 1'b0; bus.i_mode = 2'd0; bus.i_data = '0; bus.o_ready = 1'b0;

        vecs[0] = '{2'd2, pk(0, 127, 64, -128),    pk(8, 16, 16, 0),     2};
        vecs[1] = '{2'd3, pk(32, -32, 0, 127),     pk(24, -8, 0, 127),   0};
        vecs[2] = '{2'd1, pk(-5, 5, -128, 127),    pk(0, 5, 0, 127),     0};
        vecs[3] = '{2'd0, pk(1, -1, -128, 127),    pk(1, -1, -128, 127), 0};
        vecs[4] = '{2'd2, pk(-64, -65, 63, 8),     pk(0, 0, 15, 9),      1};
        vecs[5] = '{2'd3, pk(-128, 16, -1, 100),   pk(0, 10, -1, 100),   0};
        vecs[6] = '{2'd1, pk(0, -1, 1, 0),         pk(0, 0, 1, 0),       0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_o_valid", bus.o_valid, 1'b0);
        chk("rst_o_data", bus.o_data, 32'd0);
        chk("rst_sat_cnt", sat_cnt, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_i_ready", bus.i_ready, 1'b1);

        // Directed single beats
        for (int i = 0; i < 7; i++) begin
            send_one(vecs[i].mode, vecs[i].din, 1'b0);
            chk($sformatf("vec%0d_data", i), bus.o_data, vecs[i].dexp);
`ifdef PWL_SAT_CNT_EN
            exp_cnt = exp_cnt + 32'(vecs[i].nsat);
`endif
            @(negedge clk);
            chk($sformatf("vec%0d_drain", i), bus.o_valid, 1'b0);
            chk($sformatf("vec%0d_satcnt", i), sat_cnt, exp_cnt);
        end

        // Back-to-back mode 0 stream
        for (int i = 0; i < 100; i++) sq[i] = $urandom;
        bus.o_ready = 1'b1;
        for (int c = 0; c < 103; c++) begin
            @(negedge clk);
            chk("stream_i_ready", bus.i_ready, 1'b1);
            if (c >= 3) begin
                chk("stream_valid", bus.o_valid, 1'b1);
                chk("stream_data", bus.o_data, sq[c-3]);
            end else begin
                chk("stream_head_idle", bus.o_valid, 1'b0);
            end
            bus.i_valid = (c < 100);
            bus.i_mode  = 2'd0;
            bus.i_data  = (c < 100) ? sq[c] : 32'd0;
        end

        // Cycling modes under random backpressure
        sent = 0; got = 0; cyc = 0;
        cur_m = 2'd0; cur_d = $urandom;
        while (got < 40 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            bus.o_ready = 1'($urandom_range(0, 1));
            bus.i_valid = (sent < 40);
            bus.i_mode  = cur_m;
            bus.i_data  = cur_d;
            #1;
            chk("bp_i_ready", bus.i_ready, !(bus.o_valid && !bus.o_ready));
            if (bus.o_valid && bus.o_ready) begin
                if (q.size() == 0) begin
                    chk("bp_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    ev = q.pop_front();
                    chk("bp_data", bus.o_data, ev);
                end
                got++;
            end else if (!bus.o_valid) begin
                chk("bp_bubble_data", bus.o_data, 32'd0);
            end
            if (bus.i_valid && bus.i_ready) begin
                q.push_back(model(cur_m, cur_d));
                sent++;
                cur_m = cur_m + 2'd1;
                cur_d = $urandom;
            end
        end
        chk("bp_all_received", 32'(got), 32'd40);
        @(negedge clk);
        bus.i_valid = 1'b0; bus.o_ready = 1'b1;

        // Asynchronous reset with three beats in flight
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = 1'b1; bus.i_mode = 2'd0; bus.i_data = pk(i + 1, 2, 3, 4);
            @(negedge clk);
        end
        bus.i_valid = 1'b0; bus.i_data = '0;
        chk("inflight_valid", bus.o_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_o_valid", bus.o_valid, 1'b0);
        chk("arst_o_data", bus.o_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", bus.o_valid, 1'b0);
        end
        exp_cnt = 32'd0;

`ifdef PWL_SAT_CNT_EN
        // Clear wins over a simultaneous clamping handshake
        send_one(2'd2, pk(127, 127, -128, -128), 1'b0);
        @(negedge clk);
        chk("cnt_after_4", sat_cnt, 32'd4);
        send_one(2'd2, pk(127, 127, -128, -128), 1'b1);
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", sat_cnt, 32'd0);

        // Saturation at all-ones
        force dut.sat_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.sat_cnt_q;
        @(negedge clk);
        chk("cnt_preload", sat_cnt, 32'hFFFF_FFFE);
        send_one(2'd2, pk(127, 127, -128, -128), 1'b0);
        @(negedge clk);
        chk("cnt_saturate", sat_cnt, 32'hFFFF_FFFF);
`else
        send_one(2'd2, pk(127, 127, -128, -128), 1'b1);
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("cnt_disabled_zero", sat_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
